// File: rtl/shift_pipe_pkg.sv
// Shared constants for the shift_pipe block: mode encodings seen on the mode port.
package shift_pipe_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

endpackage

// File: rtl/shift_pipe_dff_stage.sv
// One WIDTH-bit pipeline stage: enabled D flip-flop with async active-low reset.
module dff_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   data_q <= '0;
        else if (en_i) data_q <= d_i;
    end

    assign q_o = data_q;

endmodule

// File: rtl/shift_pipe.sv
// Shift/rotate/clear register pipeline with occupancy count and a selectable tap.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic [$clog2(DEPTH)-1:0]   tap_sel,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           q_tap,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       full
);

    localparam int            FW       = $clog2(DEPTH+1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
    logic                        stage_en;
    logic [FW-1:0]               fill_q, fill_d;

    // Hold is folded into the stage enable, so the data mux only covers shift/rotate/clear.
    assign stage_en = en && (mode != MODE_HOLD);

    always_comb begin
        stage_d = '0;
        case (mode)
            MODE_SHIFT:  stage_d[0] = d;
            MODE_ROTATE: stage_d[0] = stage_q[DEPTH-1];
            default:     stage_d[0] = '0;
        endcase
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = (mode == MODE_CLEAR) ? '0 : stage_q[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        dff_stage #(.WIDTH(WIDTH)) u_stage (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .en_i   (stage_en),
            .d_i    (stage_d[g]),
            .q_o    (stage_q[g])
        );
    end

    always_comb begin
        fill_d = fill_q;
        if (en) begin
            case (mode)
                MODE_SHIFT: if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
                MODE_CLEAR: fill_d = '0;
                default:    fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fill_q <= '0;
        else        fill_q <= fill_d;
    end

    // Out-of-range selects only exist for non-power-of-two DEPTH; they read as zero.
    always_comb begin
        q_tap = '0;
        if (int'(tap_sel) < DEPTH) q_tap = stage_q[tap_sel];
    end

    assign q    = stage_q[DEPTH-1];
    assign fill = fill_q;
    assign full = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_shift_pipe.sv
// Randomized scoreboard bench for shift_pipe (WIDTH=8, DEPTH=4) against a queue-based model.
module tb_shift_pipe;
    import shift_pipe_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic [1:0]       tap_sel;
    logic [WIDTH-1:0] q, q_tap;
    logic [2:0]       fill;
    logic             full;

    shift_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
        .tap_sel(tap_sel), .q(q), .q_tap(q_tap), .fill(fill), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] q_tap;
        int               fill;
        logic             full;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: index 0 is the word nearest the input, the last entry is q.
    logic [WIDTH-1:0] mq[$];
    int               mfill;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < DEPTH; i++) mq.push_back('0);
        mfill = 0;
    endfunction

    function automatic void model_apply(input logic e, input logic [1:0] m, input logic [WIDTH-1:0] dd);
        logic [WIDTH-1:0] w;
        if (!e) return;
        case (m)
            MODE_SHIFT: begin
                mq.push_front(dd);
                w = mq.pop_back();
                mfill = (mfill < DEPTH) ? mfill + 1 : DEPTH;
            end
            MODE_ROTATE: begin
                w = mq.pop_back();
                mq.push_front(w);
            end
            MODE_CLEAR: model_reset();
            default: ;
        endcase
    endfunction

    function automatic void push_exp(input logic [1:0] ts, input string nm);
        exp_t e;
        e.q     = mq[DEPTH-1];
        e.q_tap = mq[ts];
        e.fill  = mfill;
        e.full  = (mfill == DEPTH);
        e.name  = nm;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (q !== e.q || q_tap !== e.q_tap || int'(fill) != e.fill || full !== e.full) begin
                miscompares++;
                $display("FAIL %s: got q=%h q_tap=%h fill=%0d full=%b, expected q=%h q_tap=%h fill=%0d full=%b",
                         e.name, q, q_tap, fill, full, e.q, e.q_tap, e.fill, e.full);
            end
        end
    end

    // Inputs change at negedge+1, the DUT samples them at posedge, the model
    // updates at posedge+1, and the monitor compares at the following negedge.
    task automatic step(input logic e, input logic [1:0] m, input logic [WIDTH-1:0] dd,
                        input logic [1:0] ts, input string nm);
        en = e; mode = m; d = dd; tap_sel = ts;
        @(posedge clk); #1;
        model_apply(e, m, dd);
        push_exp(ts, nm);
        @(negedge clk); #1;
    endtask

    task automatic fill_1234();
        step(1'b1, MODE_SHIFT, 8'h11, 2'd0, "fill_11");
        step(1'b1, MODE_SHIFT, 8'h22, 2'd0, "fill_22");
        step(1'b1, MODE_SHIFT, 8'h33, 2'd0, "fill_33");
        step(1'b1, MODE_SHIFT, 8'h44, 2'd0, "fill_44");
    endtask

    initial begin
        logic [1:0] rm;
        rst_n = 1'b0; en = 1'b0; mode = MODE_HOLD; d = '0; tap_sel = '0;
        model_reset();
        push_exp(2'd0, "reset_state");
        @(negedge clk); #1;
        rst_n = 1'b1;

        // No state change on edges with en=0 right after reset release.
        step(1'b0, MODE_SHIFT, 8'h5A, 2'd3, "post_reset_en0");

        fill_1234();
        for (int i = 0; i < 4; i++) step(1'b1, MODE_ROTATE, 8'hFF, 2'(i), "rotate");
        for (int i = 0; i < 4; i++) step(1'b1, MODE_HOLD, 8'h00, 2'(i), "tap_sweep");

        // Shift while full discards the oldest word.
        step(1'b1, MODE_SHIFT, 8'h55, 2'd3, "shift_full");

        for (int i = 0; i < 3; i++) step(1'b0, MODE_SHIFT, 8'hAA, 2'd0, "en0_hold");
        step(1'b1, MODE_SHIFT, 8'hAA, 2'd0, "en1_capture");

        step(1'b1, MODE_CLEAR, 8'h99, 2'd2, "clear");
        step(1'b0, MODE_CLEAR, 8'h00, 2'd0, "clear_hold");

        // Async reset between edges during a shift.
        fill_1234();
        en = 1'b1; mode = MODE_SHIFT; d = 8'h77; tap_sel = 2'd1;
        @(posedge clk); #1;
        model_apply(1'b1, MODE_SHIFT, 8'h77);
        #2;
        rst_n = 1'b0;
        model_reset();
        push_exp(2'd1, "async_reset");
        @(negedge clk); #1;
        en = 1'b0;
        rst_n = 1'b1;
        step(1'b0, MODE_SHIFT, 8'h12, 2'd0, "post_async_en0");

        // Randomized traffic; clear is made rare so the pipe reaches full often.
        for (int n = 0; n < 300; n++) begin
            rm = ($urandom_range(0, 19) == 0) ? MODE_CLEAR : 2'($urandom_range(0, 2));
            step(($urandom_range(0, 7) != 0), rm, 8'($urandom), 2'($urandom), "random");
        end

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, giving the data word width in bits (legal: >= 1).
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the number of register stages (legal: >= 2).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port en, input, 1 bit: stage enable; when low, all state holds.
REQ-006 The module SHALL have port mode, input, 2 bits: 00 hold, 01 shift, 10 rotate, 11 clear.
REQ-007 The module SHALL have port d, input, WIDTH bits: data captured into stage 0 on a shift.
REQ-008 The module SHALL have port tap_sel, input, $clog2(DEPTH) bits: index of the stage driven onto q_tap.
REQ-009 The module SHALL have port q, output, WIDTH bits: stage[DEPTH-1].
REQ-010 The module SHALL have port q_tap, output, WIDTH bits: stage[tap_sel], combinational.
REQ-011 The module SHALL have port fill, output, $clog2(DEPTH+1) bits: count of valid stages.
REQ-012 The module SHALL have port full, output, 1 bit: high when fill == DEPTH.

Function
REQ-013 Storage SHALL be DEPTH registers stage[0..DEPTH-1], each WIDTH bits, all updated simultaneously.
REQ-014 On en=1 with mode=01 (shift): stage[0]<=d and stage[i]<=stage[i-1] for i=1..DEPTH-1; fill SHALL increment and saturate at DEPTH.
REQ-015 A word captured on a shift SHALL appear on q after exactly DEPTH shift edges, one stage per edge, with no skipping or duplication.
REQ-016 On en=1 with mode=10 (rotate): stage[0]<=stage[DEPTH-1] and stage[i]<=stage[i-1]; d SHALL be ignored and fill SHALL be unchanged.
REQ-017 On en=1 with mode=11 (clear): all stages and fill SHALL go to 0 synchronously on that edge.
REQ-018 With mode=00, or with en=0 in any mode, all stages and fill SHALL hold.
REQ-019 Mode and en SHALL be sampled only at the rising edge; a change between edges SHALL have no effect.
REQ-020 If tap_sel >= DEPTH (non-power-of-two DEPTH), q_tap SHALL be all-zero.
REQ-021 full SHALL be a registered-state decode of fill, with no additional latency relative to fill.
REQ-022 A shift while full=1 SHALL discard the old stage[DEPTH-1] word, and fill SHALL stay at DEPTH.

Reset
REQ-023 While rst_n=0, all stages, fill and full SHALL be 0 immediately, independent of clk.
REQ-024 Reset asserted mid-operation SHALL abort any in-progress shift or rotate; no partial update SHALL survive.
REQ-025 After rst_n deasserts, the first state change SHALL occur on the first rising edge of clk with en=1.

Structure
REQ-026 The mode encodings (MODE_HOLD, MODE_SHIFT, MODE_ROTATE, MODE_CLEAR) SHALL be defined as constants in shared package shift_pipe_pkg.
REQ-027 Each stage SHALL be one instance of a sub-module dff_stage (WIDTH-bit, enable, async active-low reset), instantiated DEPTH times by a generate loop.
REQ-028 The fill counter and the tap mux SHALL live in shift_pipe itself.

Verification (WIDTH=8, DEPTH=4)
REQ-029 Scenario: reset, then shift d=0x11,0x22,0x33,0x44 on consecutive edges -> q=0x11 after the 4th edge, fill=4, full=1.
REQ-030 Scenario: from the full state 11/22/33/44, apply 4 rotate edges -> q sequence 0x22,0x33,0x44,0x11 while fill stays 4.
REQ-031 Scenario: shift 0xAA with en=0 for 3 edges, then en=1 -> no stage changes while en=0, and 0xAA enters stage[0] only on the enabled edge.
REQ-032 Scenario: full pipe, then mode=11 -> all stages 0x00, fill=0, full=0 on the next edge.
REQ-033 Scenario: assert rst_n=0 between clock edges during a shift -> q, fill and full read 0 before the next edge.
REQ-034 Scenario: full pipe, sweep tap_sel=0..3 -> q_tap = 0x44,0x33,0x22,0x11 in the same cycle.
